// File: rtl/fp_pkg.sv
// Shared widths, state encoding and operand layouts for the FP add/sub alignment stage.
package fp_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned MW    = MAN_W + 4;
    localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;
    localparam int unsigned CNT_W = $clog2(MW);

    localparam int unsigned HID = MW - 1;
    localparam int unsigned G   = 2;
    localparam int unsigned R   = 1;
    localparam int unsigned S   = 0;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        SHIFT,
        DONE
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MW-1:0]    man;
    } unp_t;

endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE single into sign, effective exponent and {hidden, frac, G, R, S} mantissa.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] op,
    output unp_t            unp_c
);

    fp_t f;

    assign f = fp_t'(op);

    // Denormals share the exponent-1 scale with a zero hidden bit.
    always_comb begin
        unp_c                     = '0;
        unp_c.sign                = f.sign;
        unp_c.exp                 = (f.exp == '0) ? EXP_W'(1) : f.exp;
        unp_c.man[HID]            = (f.exp != '0);
        unp_c.man[HID-1 -: MAN_W] = f.frac;
        unp_c.man[G:S]            = 3'b000;
    end

endmodule

// File: rtl/fp_align.sv
// Multi-cycle operand alignment: orders by magnitude, then shifts the smaller mantissa
// right one bit per cycle while folding lost bits into sticky.
module fp_align
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  a,
    input  logic [FP_W-1:0]  b,
    input  logic             flop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MW-1:0]    man_big,
    output logic [MW-1:0]    man_small,
    output logic [EXP_W-1:0] exp_out,
    output logic             sign_big,
    output logic             sign_small,
    output logic             flop_out,
    output logic             swapped
);

    state_t           state, state_nxt;
    logic [FP_W-1:0]  a_q, b_q, a_nxt, b_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             collapse, collapse_nxt;
    logic [MW-1:0]    man_big_nxt, man_small_nxt;
    logic [EXP_W-1:0] exp_nxt;
    logic             sign_big_nxt, sign_small_nxt, flop_nxt, swapped_nxt;

    unp_t             ua_c, ub_c, big_c, small_c;
    logic             a_big_c;
    logic [EXP_W-1:0] d_c;

    fp_unpack u_unpack_a (.op(a_q), .unp_c(ua_c));
    fp_unpack u_unpack_b (.op(b_q), .unp_c(ub_c));

    // Exponent decides order, mantissa breaks ties, a wins a full tie.
    always_comb begin
        a_big_c = (ua_c.exp > ub_c.exp) ||
                  ((ua_c.exp == ub_c.exp) && (ua_c.man >= ub_c.man));
        big_c   = a_big_c ? ua_c : ub_c;
        small_c = a_big_c ? ub_c : ua_c;
        d_c     = big_c.exp - small_c.exp;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        a_nxt          = a_q;
        b_nxt          = b_q;
        cnt_nxt        = cnt;
        collapse_nxt   = collapse;
        man_big_nxt    = man_big;
        man_small_nxt  = man_small;
        exp_nxt        = exp_out;
        sign_big_nxt   = sign_big;
        sign_small_nxt = sign_small;
        flop_nxt       = flop_out;
        swapped_nxt    = swapped;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_nxt     = a;
                    b_nxt     = b;
                    flop_nxt  = flop;
                    state_nxt = CMP;
                end
            end
            CMP: begin
                man_big_nxt    = big_c.man;
                man_small_nxt  = small_c.man;
                exp_nxt        = big_c.exp;
                sign_big_nxt   = big_c.sign;
                sign_small_nxt = small_c.sign;
                swapped_nxt    = !a_big_c;
                collapse_nxt   = 1'b0;
                cnt_nxt        = CNT_W'(d_c);
                if (d_c == '0) begin
                    state_nxt = DONE;
                end else if (32'(d_c) >= MW) begin
                    // Everything shifts out: one cycle reduces the mantissa to sticky.
                    cnt_nxt      = CNT_W'(1);
                    collapse_nxt = 1'b1;
                    state_nxt    = SHIFT;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (collapse) begin
                    man_small_nxt    = '0;
                    man_small_nxt[S] = |man_small;
                    state_nxt        = DONE;
                end else begin
                    man_small_nxt    = man_small >> 1;
                    man_small_nxt[S] = man_small[R] | man_small[S];
                    cnt_nxt          = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            cnt        <= '0;
            collapse   <= 1'b0;
            man_big    <= '0;
            man_small  <= '0;
            exp_out    <= '0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            flop_out   <= 1'b0;
            swapped    <= 1'b0;
        end else begin
            a_q        <= a_nxt;
            b_q        <= b_nxt;
            cnt        <= cnt_nxt;
            collapse   <= collapse_nxt;
            man_big    <= man_big_nxt;
            man_small  <= man_small_nxt;
            exp_out    <= exp_nxt;
            sign_big   <= sign_big_nxt;
            sign_small <= sign_small_nxt;
            flop_out   <= flop_nxt;
            swapped    <= swapped_nxt;
        end
    end

endmodule

// File: tb/tb_fp_align.sv
// Scoreboard bench for fp_align: directed cases plus random operands against an arithmetic model.
module tb_fp_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        flop;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] man_big, man_small;
    logic [7:0]  exp_out;
    logic        sign_big, sign_small, flop_out, swapped;

    typedef struct {
        logic [26:0] mb;
        logic [26:0] ms;
        logic [7:0]  e;
        logic        sb;
        logic        ss;
        logic        fl;
        logic        sw;
        int          lat;
        longint      t_acc;
    } exp_t;

    exp_t   sbq[$];
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_err = 0;

    fp_align dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .flop(flop), .out_valid(out_valid), .out_ready(out_ready),
        .man_big(man_big), .man_small(man_small), .exp_out(exp_out),
        .sign_big(sign_big), .sign_small(sign_small), .flop_out(flop_out),
        .swapped(swapped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Magnitude = effective exponent scaled above the mantissa; alignment is a sticky right shift.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic fl);
        exp_t            e;
        longint unsigned ea, eb, ma, mb, ebig, esmall, mbig, msmall, d, lost;
        logic            a_big;
        ea = (av[30:23] == 8'h00) ? 64'd1 : 64'(av[30:23]);
        eb = (bv[30:23] == 8'h00) ? 64'd1 : 64'(bv[30:23]);
        ma = ((av[30:23] != 8'h00) ? 64'd67108864 : 64'd0) + 64'(av[22:0]) * 64'd8;
        mb = ((bv[30:23] != 8'h00) ? 64'd67108864 : 64'd0) + 64'(bv[22:0]) * 64'd8;
        a_big  = (ea * 64'd134217728 + ma) >= (eb * 64'd134217728 + mb);
        ebig   = a_big ? ea : eb;
        esmall = a_big ? eb : ea;
        mbig   = a_big ? ma : mb;
        msmall = a_big ? mb : ma;
        d      = ebig - esmall;
        lost   = msmall & ((64'd1 << d) - 64'd1);
        e.mb   = 27'(mbig);
        e.ms   = 27'((msmall >> d) | ((lost != 0) ? 64'd1 : 64'd0));
        e.e    = 8'(ebig);
        e.sb   = a_big ? av[31] : bv[31];
        e.ss   = a_big ? bv[31] : av[31];
        e.fl   = fl;
        e.sw   = !a_big;
        e.lat  = (d == 0) ? 2 : ((d < 27) ? 2 + int'(d) : 3);
        e.t_acc = 0;
        return e;
    endfunction

    // Monitor: first valid cycle pops and compares; later valid cycles must hold steady.
    initial begin
        logic [127:0] snap;
        logic         seen;
        exp_t         e;
        seen = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    snap = {62'd0, man_big, man_small, exp_out, sign_big, sign_small, flop_out, swapped};
                    if (sbq.size() == 0) begin
                        chk("unexpected_valid", 128'(out_valid), 128'(0));
                    end else begin
                        e = sbq.pop_front();
                        chk("man_big", 128'(man_big), 128'(e.mb));
                        chk("man_small", 128'(man_small), 128'(e.ms));
                        chk("exp_out", 128'(exp_out), 128'(e.e));
                        chk("sign_big", 128'(sign_big), 128'(e.sb));
                        chk("sign_small", 128'(sign_small), 128'(e.ss));
                        chk("flop_out", 128'(flop_out), 128'(e.fl));
                        chk("swapped", 128'(swapped), 128'(e.sw));
                        chk("latency", 128'(cyc + 1 - e.t_acc), 128'(e.lat));
                    end
                end else begin
                    chk("hold_stable",
                        {62'd0, man_big, man_small, exp_out, sign_big, sign_small, flop_out, swapped}, snap);
                end
                chk("busy_in_ready", 128'(in_ready), 128'(0));
            end else begin
                seen = 1'b0;
            end
        end
    end

    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic fl, input int hold);
        exp_t e;
        int   n;
        @(negedge clk);
        a         = av;
        b         = bv;
        flop      = fl;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk("idle_in_ready", 128'(in_ready), 128'(1));
        e       = model(av, bv, fl);
        e.t_acc = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        // Keep offering junk while busy; it must be ignored.
        a    = $urandom;
        b    = $urandom;
        flop = ~fl;
        n    = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            chk("done_timeout", 128'(out_valid), 128'(1));
            sbq.delete();
        end
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_to_idle", {126'd0, in_ready, out_valid}, 128'b10);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        flop      = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready_valid", {126'd0, in_ready, out_valid}, 128'b10);
        chk("reset_data", {62'd0, man_big, man_small, exp_out, sign_big, sign_small, flop_out, swapped}, '0);
        rst_n = 1'b1;

        do_op(32'h3F800000, 32'h3F800000, 1'b0, 0);
        do_op(32'h3F800000, 32'h40800000, 1'b1, 1);
        do_op(32'h4B800000, 32'h3F800001, 1'b0, 0);
        do_op(32'h7E800000, 32'hBF800000, 1'b1, 2);
        do_op(32'h00800000, 32'h00000001, 1'b0, 5);
        do_op(32'h4D000000, 32'h3F800000, 1'b0, 0);
        do_op(32'h4D800000, 32'h3F800003, 1'b1, 0);

        // Reset in the middle of a d=20 shift.
        @(negedge clk);
        a        = 32'h49800000;
        b        = 32'h3F800000;
        flop     = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midshift_no_valid", 128'(out_valid), 128'(0));
        rst_n = 1'b0;
        #1;
        chk("midreset_ready_valid", {126'd0, in_ready, out_valid}, 128'b10);
        chk("midreset_data", {62'd0, man_big, man_small, exp_out, sign_big, sign_small, flop_out, swapped}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'h3F800000, 32'h3F800000, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, rb, t;
            int          m;
            ra = $urandom;
            rb = $urandom;
            m  = $urandom_range(0, 3);
            case (m)
                1: rb[30:23] = ra[30:23] - 8'($urandom_range(0, 30));
                2: rb[30:23] = ra[30:23];
                3: ra[30:23] = 8'h00;
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) begin
                t  = ra;
                ra = rb;
                rb = t;
            end
            do_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 128'(sbq.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_align.md
# fp_align

Multi-cycle alignment stage of the single-precision floating-point add/sub datapath. It accepts two IEEE-754 operands and an add/sub opcode over a valid/ready handshake. It orders the operands by magnitude and shifts the smaller mantissa right one bit per cycle, collecting guard/round/sticky bits. It then hands the aligned pair, the common exponent and the operand signs to the downstream sign/effective-operation stage (signComputer) and the mantissa adder.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, fraction field width; internal mantissa width MW = MAN_W+4 (hidden, fraction, G, R, S)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  stage can accept; high only in IDLE
- a, b  in  1+EXP_W+MAN_W  IEEE operands
- flop  in  1  0 = add, 1 = sub
- out_valid  out  1  aligned result present
- out_ready  in  1  downstream accepts
- man_big, man_small  out  MW  aligned mantissas; [MW-1] hidden, [2] G, [1] R, [0] S
- exp_out  out  EXP_W  common (larger) effective exponent
- sign_big, sign_small  out  1  signs of the larger/smaller-magnitude operand (feed signComputer A/B)
- flop_out  out  1  registered flop
- swapped  out  1  1 when b is the larger-magnitude operand

## Operation
- Unpack: exponent 0 → hidden bit 0, effective exponent 1. Otherwise hidden bit 1. Mantissa = {hidden, frac, 3'b000}. Inf/NaN are not special-cased (treated as ordinary exponent).
- States: IDLE, CMP, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid, capture a, b, flop and go to CMP.
- CMP: the big operand is the one with the larger effective exponent. On equal exponents, compare mantissas. On full equality, a is big and swapped=0. d = exp_big − exp_small, unsigned.
  - d = 0 → DONE.
  - 0 < d < MW → n = d, go to SHIFT.
  - d ≥ MW → n = 1 (collapse), go to SHIFT.
- SHIFT, normal: each cycle man_small ← {0, man_small[MW-1:1]}, with new bit0 = old bit1 | old bit0. Decrement n. At n = 1, go to DONE.
- SHIFT, collapse: man_small ← {(MW-1)'b0, |man_small} in one cycle, then DONE.
- DONE: out_valid=1 and all outputs stable. On out_ready, go to IDLE.
- No bypass: a new operand is never accepted in the cycle DONE is released.

## Timing
- Accept at edge t; CMP at t+1; out_valid rises 2+n cycles after accept. n = 0 for d = 0, so minimum latency is 2 and maximum is 2+(MW-1) = 28.
- Throughput: one operation per 3+n cycles with out_ready held high.
- in_ready = (state == IDLE), combinational from the state register.
- out_valid = (state == DONE). Outputs are registered and constant while out_valid is high and out_ready is low.
- Reset (asynchronous, any state, including mid-SHIFT):
  - state IDLE, out_valid 0, in_ready 1.
  - man_big, man_small, exp_out, sign_big, sign_small, flop_out and swapped all 0.
  - The in-flight operation is discarded.
- in_valid while not IDLE is ignored (held by upstream).

## Structure
- Package fp_pkg holds:
  - EXP_W, MAN_W, MW
  - state enum {IDLE, CMP, SHIFT, DONE}
  - bit-position constants HID = MW-1, G = 2, R = 1, S = 0
- One combinational sub-module, fp_unpack: field split, hidden-bit and denormal effective-exponent logic. It is instantiated twice.
- The shift counter is ceil(log2(MW)) bits wide.

## Test plan
- Equal operands: a = b = 0x3F800000, flop=0.
  - out_valid 2 cycles after accept.
  - exp_out=0x7F, man_big=man_small=0x4000000, swapped=0.
- Swap and shift: a=0x3F800000 (1.0), b=0x40800000 (4.0), flop=1.
  - Latency 4, swapped=1, exp_out=0x81.
  - man_big=0x4000000, man_small=0x1000000, sign_big=sign_small=0, flop_out=1.
- Sticky collection: a=0x4B800000, b=0x3F800001 (d=24).
  - man_small=0x0000005 (G set, S set from lost LSB).
  - Latency 26.
- Collapse: a=0x7E800000, b=0xBF800000 (d=126).
  - man_small=0x0000001, latency 3, sign_small=1.
- Denormal plus backpressure: a=0x00800000, b=0x00000001.
  - Both effective exponents 1, d=0, swapped=0, man_small=0x0000008.
  - Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0.
  - Release: IDLE the next cycle, new accept possible.
- Reset mid-SHIFT: assert rst_n=0 during a d=20 operation.
  - out_valid=0 and in_ready=1 immediately, all data outputs 0.
  - After release, a fresh 1.0 + 1.0 completes with latency 2.
